// File: rtl/cpc_ram512k_ctrl.sv
// cpc_ram512k_ctrl
//   Bank controller for the 512K CPC RAM expansion (XC9572 CPLD).
//   Snoops Z80 writes to the gate-array RAM port (&7Fxx with D7:6 = 11).
//   Holds the 6-bit configuration {bank[2:0], mode[2:0]}.
//   Maps each memory cycle onto the external SRAM and tells the CPC's
//   internal RAM to yield on the cycles it claims.
//
// Ports
//   CLK, RESET_B         4 MHz bus clock, async active-low reset
//   A15, A14             Z80 address bits (port select / 16K slot)
//   D[7:0]               Z80 data bus
//   IOREQ_B .. RFSH_B    Z80 control strobes, active low
//   RAMRD_B              low when RAM (not ROM) supplies a read
//   dip0, dip1           expansion enable, 6128 host (bank 0 internal)
//   HIADR[4:0]           SRAM A18:14 = {bank, 16K block}
//   RAMCS_B/WE_B/OE_B    SRAM strobes, active low
//   RAMDIS               high disables the CPC internal RAM
//   cfg_q[5:0]           committed configuration, for probes
module cpc_ram512k_ctrl #(
   parameter int unsigned NUM_BANKS = 8
) (
   input  logic       CLK,
   input  logic       RESET_B,
   input  logic       A15,
   input  logic       A14,
   input  logic [7:0] D,
   input  logic       IOREQ_B,
   input  logic       MREQ_B,
   input  logic       RD_B,
   input  logic       WR_B,
   input  logic       M1_B,
   input  logic       RFSH_B,
   input  logic       RAMRD_B,
   input  logic       dip0,
   input  logic       dip1,
   output logic [4:0] HIADR,
   output logic       RAMCS_B,
   output logic       RAMWE_B,
   output logic       RAMOE_B,
   output logic       RAMDIS,
   output logic [5:0] cfg_q
);

   typedef enum logic [1:0] {StIdle, StCapture, StHold} state_e;

   state_e     state_q;
   logic [5:0] pend_q;
   logic       qw;

   // M1_B low with IOREQ_B low is an interrupt acknowledge, not a port write.
   assign qw = !IOREQ_B && !WR_B && !A15 && M1_B && D[7] && D[6];

   // Data is resampled while WR_B stays low, so the value committed is the one
   // present just before the strobe releases. HOLD blocks a second commit
   // within the same IO cycle.
   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         state_q <= StIdle;
         pend_q  <= 6'd0;
         cfg_q   <= 6'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (qw) begin
                  pend_q  <= D[5:0];
                  state_q <= StCapture;
               end
            end
            StCapture: begin
               if (!WR_B) begin
                  pend_q <= D[5:0];
               end else begin
                  cfg_q   <= pend_q;
                  state_q <= StHold;
               end
            end
            StHold: begin
               if (IOREQ_B) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   logic [2:0] bank;
   logic [2:0] mode;
   logic [1:0] slot;
   logic       claim;
   logic [1:0] blk;
   logic       bank_ok;
   logic       hit;
   logic       active;

   assign bank = cfg_q[5:3];
   assign mode = cfg_q[2:0];
   assign slot = {A15, A14};

   // Mode 3 only claims slot 3 here; its slot-1 remap is done by the host.
   always_comb begin
      claim = 1'b0;
      blk   = slot;
      case (mode)
         3'd1, 3'd3: begin
            if (slot == 2'd3) begin
               claim = 1'b1;
               blk   = 2'd3;
            end
         end
         3'd2: begin
            claim = 1'b1;
            blk   = slot;
         end
         3'd4, 3'd5, 3'd6, 3'd7: begin
            if (slot == 2'd1) begin
               claim = 1'b1;
               blk   = mode[1:0];
            end
         end
         default: ;
      endcase
   end

   assign bank_ok = ({29'd0, bank} < NUM_BANKS);
   assign hit     = dip0 && claim && bank_ok && !(dip1 && (bank == 3'd0));
   assign HIADR   = hit ? {bank, blk} : {bank, slot};

   // Refresh cycles never reach the SRAM.
   assign active  = hit && !MREQ_B && RFSH_B;
   assign RAMDIS  = active;
   assign RAMCS_B = !active;
   assign RAMWE_B = !(active && !WR_B);
   assign RAMOE_B = !(active && !RD_B && !RAMRD_B);

endmodule

// File: tb/tb_cpc_ram512k_ctrl.sv
module tb_cpc_ram512k_ctrl;

   logic       CLK = 1'b0;
   logic       RESET_B = 1'b0;
   logic       A15 = 1'b0, A14 = 1'b0;
   logic [7:0] D = 8'h00;
   logic       IOREQ_B = 1'b1, MREQ_B = 1'b1, RD_B = 1'b1, WR_B = 1'b1;
   logic       M1_B = 1'b1, RFSH_B = 1'b1, RAMRD_B = 1'b1;
   logic       dip0 = 1'b1, dip1 = 1'b0;

   logic [4:0] hiadr8, hiadr4;
   logic       cs8, we8, oe8, dis8, cs4, we4, oe4, dis4;
   logic [5:0] cfg8, cfg4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   cpc_ram512k_ctrl #(.NUM_BANKS(8)) dut8 (
      .CLK(CLK), .RESET_B(RESET_B), .A15(A15), .A14(A14), .D(D),
      .IOREQ_B(IOREQ_B), .MREQ_B(MREQ_B), .RD_B(RD_B), .WR_B(WR_B), .M1_B(M1_B),
      .RFSH_B(RFSH_B), .RAMRD_B(RAMRD_B), .dip0(dip0), .dip1(dip1),
      .HIADR(hiadr8), .RAMCS_B(cs8), .RAMWE_B(we8), .RAMOE_B(oe8), .RAMDIS(dis8),
      .cfg_q(cfg8)
   );

   cpc_ram512k_ctrl #(.NUM_BANKS(4)) dut4 (
      .CLK(CLK), .RESET_B(RESET_B), .A15(A15), .A14(A14), .D(D),
      .IOREQ_B(IOREQ_B), .MREQ_B(MREQ_B), .RD_B(RD_B), .WR_B(WR_B), .M1_B(M1_B),
      .RFSH_B(RFSH_B), .RAMRD_B(RAMRD_B), .dip0(dip0), .dip1(dip1),
      .HIADR(hiadr4), .RAMCS_B(cs4), .RAMWE_B(we4), .RAMOE_B(oe4), .RAMDIS(dis4),
      .cfg_q(cfg4)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full OUT cycle: two CLKs with WR_B low, release, then IOREQ_B release.
   task automatic io_out(input logic a15, input logic [7:0] data);
      @(negedge CLK);
      A15 = a15; D = data; M1_B = 1'b1; IOREQ_B = 1'b0; WR_B = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      WR_B = 1'b1;
      @(negedge CLK);
      IOREQ_B = 1'b1;
      @(negedge CLK);
   endtask

   // Drive a memory cycle (bus left active for inspection).
   task automatic mem(input logic [1:0] s, input logic rd, input logic ramrd);
      @(negedge CLK);
      {A15, A14} = s; MREQ_B = 1'b0; RFSH_B = 1'b1;
      RD_B = !rd; WR_B = rd; RAMRD_B = !ramrd;
      #1;
   endtask

   task automatic mem_end();
      MREQ_B = 1'b1; RD_B = 1'b1; WR_B = 1'b1; RAMRD_B = 1'b1; RFSH_B = 1'b1;
   endtask

   initial begin
      // 1: reset state
      #12;
      @(negedge CLK);
      RESET_B = 1'b1;
      check("reset_cfg", {2'b0, cfg8}, 8'h00);
      mem(2'd1, 1'b1, 1'b1);
      check("reset_dis", {7'b0, dis8}, 8'h0);
      check("reset_cs", {7'b0, cs8}, 8'h1);
      check("reset_hiadr", {3'b0, hiadr8}, 8'h01);
      mem_end();

      // 2: mode 4 bank 0; commit only after WR_B release
      @(negedge CLK);
      A15 = 1'b0; D = 8'hC4; IOREQ_B = 1'b0; WR_B = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      check("no_commit_while_wr", {2'b0, cfg8}, 8'h00);
      WR_B = 1'b1;
      @(negedge CLK);
      check("commit_c4", {2'b0, cfg8}, 8'h04);
      IOREQ_B = 1'b1;
      @(negedge CLK);
      mem(2'd1, 1'b1, 1'b1);
      check("m4_hiadr", {3'b0, hiadr8}, 8'h00);
      check("m4_dis", {7'b0, dis8}, 8'h1);
      check("m4_oe", {7'b0, oe8}, 8'h0);
      check("m4_we_on_read", {7'b0, we8}, 8'h1);
      mem_end();
      mem(2'd1, 1'b1, 1'b0);
      check("rom_read_oe", {7'b0, oe8}, 8'h1);
      check("rom_read_cs", {7'b0, cs8}, 8'h0);
      mem_end();
      mem(2'd2, 1'b1, 1'b1);
      check("m4_slot2_dis", {7'b0, dis8}, 8'h0);
      check("m4_slot2_hiadr", {3'b0, hiadr8}, 8'h02);
      mem_end();

      // 3: resampled data (C0 then D7) commits D7; HOLD blocks a second commit
      @(negedge CLK);
      A15 = 1'b0; D = 8'hC0; IOREQ_B = 1'b0; WR_B = 1'b0;
      @(negedge CLK);
      D = 8'hD7;
      @(negedge CLK);
      WR_B = 1'b1;
      @(negedge CLK);
      check("commit_d7", {2'b0, cfg8}, 8'h17);
      D = 8'hC1; WR_B = 1'b0;
      @(negedge CLK);
      WR_B = 1'b1;
      @(negedge CLK);
      check("hold_one_commit", {2'b0, cfg8}, 8'h17);
      IOREQ_B = 1'b1;
      @(negedge CLK);
      mem(2'd1, 1'b0, 1'b0);
      check("m7_hiadr", {3'b0, hiadr8}, 8'h0B);
      check("m7_we", {7'b0, we8}, 8'h0);
      check("m7_oe_on_write", {7'b0, oe8}, 8'h1);
      mem_end();
      io_out(1'b0, 8'hC2);
      check("commit_c2", {2'b0, cfg8}, 8'h02);
      mem(2'd3, 1'b1, 1'b1);
      check("m2_hiadr", {3'b0, hiadr8}, 8'h03);
      check("m2_cs", {7'b0, cs8}, 8'h0);
      mem_end();
      mem(2'd0, 1'b1, 1'b1);
      check("m2_slot0_hiadr", {3'b0, hiadr8}, 8'h00);
      check("m2_slot0_dis", {7'b0, dis8}, 8'h1);
      mem_end();

      // 4: 6128 host, bank 0 never claimed
      dip1 = 1'b1;
      io_out(1'b0, 8'hC4);
      mem(2'd1, 1'b1, 1'b1);
      check("6128_b0_dis", {7'b0, dis8}, 8'h0);
      check("6128_b0_cs", {7'b0, cs8}, 8'h1);
      check("6128_b0_hiadr", {3'b0, hiadr8}, 8'h01);
      mem_end();
      io_out(1'b0, 8'hCC);
      mem(2'd1, 1'b1, 1'b1);
      check("6128_b1_hiadr", {3'b0, hiadr8}, 8'h04);
      check("6128_b1_dis", {7'b0, dis8}, 8'h1);
      mem_end();

      // 5: non-qualifying writes and refresh
      io_out(1'b0, 8'h8C);
      check("pen_write_ignored", {2'b0, cfg8}, 8'h0C);
      io_out(1'b1, 8'hC4);
      check("a15_write_ignored", {2'b0, cfg8}, 8'h0C);
      @(negedge CLK);
      A15 = 1'b0; D = 8'hC4; M1_B = 1'b0; IOREQ_B = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      IOREQ_B = 1'b1; M1_B = 1'b1;
      @(negedge CLK);
      check("int_ack_ignored", {2'b0, cfg8}, 8'h0C);
      mem(2'd1, 1'b1, 1'b1);
      RFSH_B = 1'b0;
      #1;
      check("refresh_cs", {7'b0, cs8}, 8'h1);
      check("refresh_dis", {7'b0, dis8}, 8'h0);
      RFSH_B = 1'b1;
      dip0 = 1'b0;
      #1;
      check("dip0_off_dis", {7'b0, dis8}, 8'h0);
      dip0 = 1'b1;
      #1;
      check("dip0_on_dis", {7'b0, dis8}, 8'h1);
      mem_end();

      // 6: bank 5 beyond NUM_BANKS=4; reset during CAPTURE
      io_out(1'b0, 8'hEC);
      check("b5_cfg4", {2'b0, cfg4}, 8'h2C);
      check("b5_cfg8", {2'b0, cfg8}, 8'h2C);
      mem(2'd1, 1'b1, 1'b1);
      check("b5_n4_dis", {7'b0, dis4}, 8'h0);
      check("b5_n4_hiadr", {3'b0, hiadr4}, 8'h15);
      check("b5_n8_dis", {7'b0, dis8}, 8'h1);
      check("b5_n8_hiadr", {3'b0, hiadr8}, 8'h14);
      mem_end();
      @(negedge CLK);
      A15 = 1'b0; D = 8'hD7; IOREQ_B = 1'b0; WR_B = 1'b0;
      @(posedge CLK);
      #2;
      RESET_B = 1'b0;
      #1;
      check("async_reset_cfg", {2'b0, cfg8}, 8'h00);
      @(negedge CLK);
      IOREQ_B = 1'b1; WR_B = 1'b1;
      @(negedge CLK);
      RESET_B = 1'b1;
      @(negedge CLK);
      check("post_reset_cfg", {2'b0, cfg8}, 8'h00);
      io_out(1'b0, 8'hC4);
      check("post_reset_commit", {2'b0, cfg8}, 8'h04);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
